// File: rtl/dual_adc_capture_pkg.sv
// Shared definitions for the dual-channel ADC capture engine.
package dual_adc_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Cycles from an accepted rd_en to rd_data/rd_valid.
    localparam int unsigned RD_LATENCY = 1;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample RAM: synchronous write, synchronous registered read.
module capture_ram #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [0:(1 << ADDR_W)-1];
    logic [WIDTH-1:0] r_rdata;

    // Write port and registered read port; no reset so block RAM is inferred.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dual_adc_capture.sv
// Dual-channel ADC capture: sample clock generation, level trigger on
// channel A, DEPTH-pair capture into RAM and pipelined readback.
module dual_adc_capture
    import dual_adc_capture_pkg::*;
#(
    parameter int unsigned BITS       = 8,
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter int unsigned CLK_DIV    = 4
) (
    input  logic              clk,
    input  logic              aReset,
    output logic              adc_a_c,
    output logic              adc_b_c,
    input  logic [BITS-1:0]   adc_a_d,
    input  logic [BITS-1:0]   adc_b_d,
    input  logic              arm,
    input  logic              force_trig,
    input  logic [BITS-1:0]   trig_level,
    input  logic              trig_edge,
    input  logic              rd_en,
    output logic [2*BITS-1:0] rd_data,
    output logic              rd_valid,
    output logic [1:0]        state
);

    localparam int unsigned          DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]     DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [DEPTH_LOG2-1:0] PTR_LAST = '1;
    localparam int unsigned          VLD_W    = RD_LATENCY;

    logic [DIV_W-1:0]      r_div_cnt;
    logic                  r_adc_c;
    logic [BITS-1:0]       r_sa;
    logic [BITS-1:0]       r_sb;
    logic [BITS-1:0]       r_prev_a;
    logic                  r_prev_ok;
    state_t                r_state;
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [VLD_W-1:0]      r_rd_pipe;

    logic                  w_stb;
    logic                  w_cross;
    logic                  w_trig;
    logic                  w_we;
    logic [DEPTH_LOG2-1:0] w_waddr;
    logic                  w_re;
    logic [2*BITS-1:0]     w_ram_q;

    // Sample-period divider and registered ADC sample clock.
    always_ff @(posedge clk or posedge aReset) begin
        if (aReset) begin
            r_div_cnt <= '0;
            r_adc_c   <= 1'b0;
        end else begin
            r_div_cnt <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + 1'b1;
            r_adc_c   <= (r_div_cnt < DIV_HALF);
        end
    end

    // Input registers for both sample buses, loaded every clock.
    always_ff @(posedge clk or posedge aReset) begin
        if (aReset) begin
            r_sa <= '0;
            r_sb <= '0;
        end else begin
            r_sa <= adc_a_d;
            r_sb <= adc_b_d;
        end
    end

    // Strobe, trigger compare, RAM write/read enables; arm blocks all of them.
    always_comb begin
        w_stb   = (r_div_cnt == DIV_LAST);
        w_cross = trig_edge ? ((r_prev_a <  trig_level) && (r_sa >= trig_level))
                            : ((r_prev_a >= trig_level) && (r_sa <  trig_level));
        w_trig  = force_trig || (r_prev_ok && w_cross);
        w_we    = !arm && w_stb &&
                  (((r_state == ST_ARMED) && w_trig) || (r_state == ST_CAPTURE));
        w_waddr = (r_state == ST_ARMED) ? '0 : r_wr_ptr;
        w_re    = !arm && rd_en && (r_state == ST_DONE);
    end

    // Capture FSM with write/read pointers; arm restarts from any state.
    always_ff @(posedge clk or posedge aReset) begin
        if (aReset) begin
            r_state   <= ST_IDLE;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_prev_a  <= '0;
            r_prev_ok <= 1'b0;
        end else if (arm) begin
            r_state   <= ST_ARMED;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_prev_ok <= 1'b0;
        end else begin
            case (r_state)
                ST_ARMED: begin
                    if (w_stb) begin
                        r_prev_a  <= r_sa;
                        r_prev_ok <= 1'b1;
                        if (w_trig) begin
                            r_wr_ptr <= DEPTH_LOG2'(1);
                            r_state  <= ST_CAPTURE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (w_stb) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                        if (r_wr_ptr == PTR_LAST) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (rd_en) begin
                        if (r_rd_ptr == PTR_LAST) begin
                            r_rd_ptr <= '0;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_rd_ptr <= r_rd_ptr + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Read-valid pipeline matching the RAM read latency; unaffected by arm.
    always_ff @(posedge clk or posedge aReset) begin
        if (aReset) begin
            r_rd_pipe <= '0;
        end else begin
            r_rd_pipe <= (r_rd_pipe << 1) | VLD_W'(w_re);
        end
    end

    capture_ram #(
        .WIDTH  (2 * BITS),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata ({r_sb, r_sa}),
        .i_re    (w_re),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_ram_q)
    );

    // The RAM output register has no reset, so rd_data is held at zero unless valid.
    assign rd_valid = r_rd_pipe[VLD_W-1];
    assign rd_data  = rd_valid ? w_ram_q : '0;
    assign adc_a_c  = r_adc_c;
    assign adc_b_c  = r_adc_c;
    assign state    = r_state;

endmodule

// File: tb/tb_dual_adc_capture.sv
// Directed testbench for dual_adc_capture (CLK_DIV=4, DEPTH_LOG2=4).
module tb_dual_adc_capture;

    logic        clk = 1'b0;
    logic        aReset;
    logic        adc_a_c, adc_b_c;
    logic [7:0]  adc_a_d, adc_b_d;
    logic        arm, force_trig, trig_edge, rd_en;
    logic [7:0]  trig_level;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic [1:0]  state;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [15:0] exp_mem [16];
    longint      t0, t1, t2;

    dual_adc_capture #(
        .BITS       (8),
        .DEPTH_LOG2 (4),
        .CLK_DIV    (4)
    ) dut (
        .clk        (clk),
        .aReset     (aReset),
        .adc_a_c    (adc_a_c),
        .adc_b_c    (adc_b_c),
        .adc_a_d    (adc_a_d),
        .adc_b_d    (adc_b_d),
        .arm        (arm),
        .force_trig (force_trig),
        .trig_level (trig_level),
        .trig_edge  (trig_edge),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .state      (state)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic wait_rise();
        logic prev;
        prev = adc_a_c;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!prev && adc_a_c) break;
            prev = adc_a_c;
        end
    endtask

    task automatic put_sample(input logic [7:0] a, input logic [7:0] b, input logic f);
        wait_rise();
        adc_a_d    = a;
        adc_b_d    = b;
        force_trig = f;
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (state == s) break;
            @(negedge clk);
        end
        check(tag, 32'(state), 32'(s));
    endtask

    task automatic pulse_arm();
        @(negedge clk);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic rd_pulse_expect_none(input string tag);
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check(tag, 32'(rd_valid), 32'd0);
        @(negedge clk);
        check(tag, 32'(rd_valid), 32'd0);
    endtask

    task automatic read_burst(input string tag);
        @(negedge clk);
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 15) rd_en = 1'b0;
            check({tag, "_valid"}, 32'(rd_valid), 32'd1);
            check({tag, "_data"}, 32'(rd_data), 32'(exp_mem[i]));
        end
        check({tag, "_idle"}, 32'(state), 32'd0);
        @(negedge clk);
        check({tag, "_novalid"}, 32'(rd_valid), 32'd0);
    endtask

    task automatic read_single(input string tag);
        for (int i = 0; i < 16; i++) begin
            check({tag, "_done"}, 32'(state), 32'd3);
            @(negedge clk);
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
            check({tag, "_valid"}, 32'(rd_valid), 32'd1);
            check({tag, "_data"}, 32'(rd_data), 32'(exp_mem[i]));
            @(negedge clk);
            check({tag, "_pulse"}, 32'(rd_valid), 32'd0);
        end
        check({tag, "_idle"}, 32'(state), 32'd0);
    endtask

    initial begin
        aReset     = 1'b1;
        adc_a_d    = 8'h00;
        adc_b_d    = 8'h00;
        arm        = 1'b0;
        force_trig = 1'b0;
        trig_edge  = 1'b1;
        trig_level = 8'h80;
        rd_en      = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_state", 32'(state), 32'd0);
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_adc_c", 32'(adc_a_c), 32'd0);
        check("rst_data", 32'(rd_data), 32'd0);
        aReset = 1'b0;

        // Reset mid-stream while ARMED with the sample clock high
        pulse_arm();
        check("arm_state", 32'(state), 32'd1);
        wait_rise();
        check("adc_high", 32'(adc_a_c), 32'd1);
        #2 aReset = 1'b1;
        #1;
        check("midrst_state", 32'(state), 32'd0);
        check("midrst_adc_a", 32'(adc_a_c), 32'd0);
        check("midrst_adc_b", 32'(adc_b_c), 32'd0);
        check("midrst_valid", 32'(rd_valid), 32'd0);
        @(negedge clk);
        aReset = 1'b0;
        t0 = $time;
        wait_rise();
        t1 = $time;
        wait_rise();
        t2 = $time;
        check("adc_first_rise", 32'(t1 - t0), 32'd10);
        check("adc_period", 32'(t2 - t1), 32'd40);
        check("adc_b_equal", 32'(adc_b_c), 32'(adc_a_c));

        // rd_en in IDLE is ignored
        rd_pulse_expect_none("rd_idle");

        // Rising trigger at 0x80
        trig_level = 8'h80;
        trig_edge  = 1'b1;
        adc_a_d    = 8'h70;
        pulse_arm();
        check("rise_armed", 32'(state), 32'd1);
        rd_pulse_expect_none("rd_armed");
        for (int i = 0; i < 18; i++) begin
            put_sample(8'(8'h70 + 8 * i), 8'(8'h20 + i), 1'b0);
            if (i == 2) check("rise_wait", 32'(state), 32'd1);
            if (i == 3) check("rise_trig", 32'(state), 32'd2);
        end
        for (int j = 0; j < 16; j++) exp_mem[j] = {8'(8'h22 + j), 8'(8'h80 + 8 * j)};
        wait_state(2'd3, 20, "rise_done");
        read_burst("rise_rd");

        // Falling trigger at 0x40; a flat 0x40 must not trigger
        trig_level = 8'h40;
        trig_edge  = 1'b0;
        adc_a_d    = 8'h40;
        adc_b_d    = 8'h90;
        pulse_arm();
        repeat (40) @(negedge clk);
        check("fall_flat", 32'(state), 32'd1);
        for (int i = 0; i < 19; i++) begin
            put_sample(8'(8'h48 - 4 * i), 8'(8'h90 + i), 1'b0);
            if (i == 3) check("fall_wait", 32'(state), 32'd1);
            if (i == 4) check("fall_trig", 32'(state), 32'd2);
        end
        for (int j = 0; j < 16; j++) exp_mem[j] = {8'(8'h93 + j), 8'(8'h3C - 4 * j)};
        wait_state(2'd3, 20, "fall_done");
        read_burst("fall_rd");

        // force_trig on constant data, isolated reads
        trig_level = 8'h00;
        trig_edge  = 1'b1;
        adc_a_d    = 8'h55;
        adc_b_d    = 8'hAA;
        pulse_arm();
        put_sample(8'h55, 8'hAA, 1'b1);
        put_sample(8'h55, 8'hAA, 1'b0);
        check("force_trig", 32'(state), 32'd2);
        for (int j = 0; j < 16; j++) exp_mem[j] = 16'hAA55;
        wait_state(2'd3, 100, "force_done");
        read_single("force_rd");

        // Re-arm in CAPTURE at wr_ptr=7, then refill from address 0
        trig_level = 8'hFF;
        trig_edge  = 1'b1;
        adc_a_d    = 8'hEE;
        adc_b_d    = 8'hEE;
        pulse_arm();
        put_sample(8'hEE, 8'hEE, 1'b1);
        put_sample(8'hEE, 8'hEE, 1'b0);
        repeat (23) @(negedge clk);
        check("abort_capture", 32'(state), 32'd2);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        check("abort_armed", 32'(state), 32'd1);
        for (int i = 0; i < 17; i++) begin
            put_sample(8'(i), 8'(8'h80 + i), (i == 0) ? 1'b1 : 1'b0);
        end
        for (int j = 0; j < 16; j++) exp_mem[j] = {8'(8'h80 + j), 8'(j)};
        wait_state(2'd3, 20, "rearm_done");
        read_burst("rearm_rd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
